weight_rd_sequencer: RTL and testbench

- Read-side address generator for the double-buffered weight RAM loader.
- After a layer's weights are loaded, it walks the weight RAM depth in compute order (co group outer, pixel tile, kernel position, ci group inner) and drives the loader's read depth and read-valid.
- It emits first/last accumulation flags. These are delayed to line up with the loader's weight output, so the PE array knows when to clear and when to flush its accumulators.

---
 rtl/weight_rd_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_weight_rd_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_rd_sequencer.sv
// Read-side address generator for the double-buffered weight RAM loader.
// Walks the RAM in compute order and emits first/last accumulation flags aligned to weight output.
`timescale 1ns/1ps
module weight_rd_sequencer #(
    parameter int unsigned LITEWIDTH = 32,
    parameter int unsigned COWIDTH   = 10,
    parameter int unsigned CH_IN     = 16,
    parameter int unsigned CH_OUT    = 32,
    parameter int unsigned PIXWIDTH  = 16,
    parameter int unsigned RD_LAT    = 4
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic [LITEWIDTH-1:0] I_kx_num,
    input  logic [LITEWIDTH-1:0] I_ky_num,
    input  logic [12:0]          I_ciAlign,
    input  logic [12:0]          I_coAlign,
    input  logic [PIXWIDTH-1:0]  I_pix_num,
    input  logic                 I_ap_start,
    input  logic                 I_load_done,
    input  logic                 I_stall,
    output logic [COWIDTH-2:0]   O_rd_wdepth,
    output logic                 O_rd_dv,
    output logic                 O_w_dv,
    output logic                 O_w_first,
    output logic                 O_w_last,
    output logic                 O_busy,
    output logic                 O_done,
    output logic                 O_cfg_err
);

    localparam int unsigned AW    = COWIDTH - 1;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CI_SH = $clog2(CH_IN);
    localparam int unsigned CO_SH = $clog2(CH_OUT);
    localparam int unsigned CIGW  = 13 - CI_SH;
    localparam int unsigned COGW  = 13 - CO_SH;
    localparam int unsigned KXKW  = AW + 1;
    localparam int unsigned KSW   = CIGW + COGW;
    localparam int unsigned TOTW  = KXKW + KSW;
    localparam int unsigned KFW   = 2 * LITEWIDTH;

    localparam logic [KFW-1:0]  KXK_MAX = KFW'(DEPTH);
    localparam logic [TOTW-1:0] TOT_MAX = TOTW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWaitLoad,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic                ap_d1_q, ap_d2_q;
    logic                start;
    logic [1:0]          setup_cnt_q, setup_cnt_d;

    logic [KXKW-1:0]     kxk_q, kxk_d;
    logic                kxk_ovf_q, kxk_ovf_d;
    logic [CIGW-1:0]     cig_num_q, cig_num_d;
    logic [COGW-1:0]     cog_num_q, cog_num_d;
    logic [KSW-1:0]      kstep_q, kstep_d;
    logic [PIXWIDTH-1:0] pix_num_q, pix_num_d;

    logic [CIGW-1:0]     cig_cnt_q, cig_cnt_d;
    logic [KXKW-1:0]     k_cnt_q, k_cnt_d;
    logic [PIXWIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [COGW-1:0]     cog_cnt_q, cog_cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       kbase_q, kbase_d;

    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic                rd_dv_q, rd_dv_d;
    logic                rd_first_q, rd_first_d;
    logic                rd_last_q, rd_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;

    logic [2:0]          dly_q [RD_LAT];

    logic [KFW-1:0]      kxk_full;
    logic [TOTW-1:0]     total;
    logic                cfg_bad;
    logic                cig_last, k_last, pix_last, cog_last;
    logic [AW-1:0]       kbase_step;

    // Low alignment bits are always zero by construction.
    logic unused_align;
    assign unused_align = ^{I_ciAlign[CI_SH-1:0], I_coAlign[CO_SH-1:0]};

    assign start = ap_d1_q & ~ap_d2_q;

    assign kxk_full   = KFW'(I_kx_num) * KFW'(I_ky_num);
    assign total      = TOTW'(kxk_q) * TOTW'(kstep_q);
    assign cfg_bad    = kxk_ovf_q || (total > TOT_MAX) || (kxk_q == '0) ||
                        (cig_num_q == '0) || (cog_num_q == '0);

    assign cig_last   = (cig_cnt_q == cig_num_q - CIGW'(1));
    assign k_last     = (k_cnt_q == kxk_q - KXKW'(1));
    assign pix_last   = (pix_cnt_q == pix_num_q - PIXWIDTH'(1));
    assign cog_last   = (cog_cnt_q == cog_num_q - COGW'(1));
    assign kbase_step = kbase_q + AW'(kstep_q);

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        kxk_d       = kxk_q;
        kxk_ovf_d   = kxk_ovf_q;
        cig_num_d   = cig_num_q;
        cog_num_d   = cog_num_q;
        kstep_d     = kstep_q;
        pix_num_d   = pix_num_q;
        cig_cnt_d   = cig_cnt_q;
        k_cnt_d     = k_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        cog_cnt_d   = cog_cnt_q;
        addr_d      = addr_q;
        kbase_d     = kbase_q;
        rd_addr_d   = rd_addr_q;
        rd_dv_d     = 1'b0;
        rd_first_d  = 1'b0;
        rd_last_d   = 1'b0;
        cfg_err_d   = cfg_err_q;
        busy_d      = (state_q == StSetup) || (state_q == StWaitLoad) || (state_q == StRun);
        done_d      = (state_q == StDone);

        if (start) begin
            // A start edge anywhere aborts the current layer and reissues setup.
            state_d     = StSetup;
            setup_cnt_d = '0;
            cfg_err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StSetup: begin
                    setup_cnt_d = setup_cnt_q + 2'd1;
                    case (setup_cnt_q)
                        2'd0: begin
                            kxk_d     = kxk_full[KXKW-1:0];
                            kxk_ovf_d = (kxk_full > KXK_MAX);
                            cig_num_d = I_ciAlign[12:CI_SH];
                            cog_num_d = I_coAlign[12:CO_SH];
                            pix_num_d = I_pix_num;
                        end
                        2'd1: begin
                            kstep_d = KSW'(cig_num_q) * KSW'(cog_num_q);
                        end
                        default: begin
                            cig_cnt_d = '0;
                            k_cnt_d   = '0;
                            pix_cnt_d = '0;
                            cog_cnt_d = '0;
                            addr_d    = '0;
                            kbase_d   = '0;
                            if (cfg_bad) begin
                                cfg_err_d = 1'b1;
                                state_d   = StDone;
                            end else if (pix_num_q == '0) begin
                                state_d = StDone;
                            end else begin
                                state_d = StWaitLoad;
                            end
                        end
                    endcase
                end
                StWaitLoad: begin
                    if (I_load_done) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!I_stall) begin
                        rd_dv_d    = 1'b1;
                        rd_addr_d  = addr_q;
                        rd_first_d = (k_cnt_q == '0) && (cig_cnt_q == '0);
                        rd_last_d  = k_last && cig_last;
                        if (!cig_last) begin
                            cig_cnt_d = cig_cnt_q + CIGW'(1);
                            addr_d    = addr_q + AW'(cog_num_q);
                        end else begin
                            cig_cnt_d = '0;
                            if (!k_last) begin
                                k_cnt_d = k_cnt_q + KXKW'(1);
                                kbase_d = kbase_step;
                                addr_d  = kbase_step;
                            end else begin
                                k_cnt_d = '0;
                                if (!pix_last) begin
                                    pix_cnt_d = pix_cnt_q + PIXWIDTH'(1);
                                    kbase_d   = AW'(cog_cnt_q);
                                    addr_d    = AW'(cog_cnt_q);
                                end else begin
                                    pix_cnt_d = '0;
                                    if (!cog_last) begin
                                        cog_cnt_d = cog_cnt_q + COGW'(1);
                                        kbase_d   = AW'(cog_cnt_q + COGW'(1));
                                        addr_d    = AW'(cog_cnt_q + COGW'(1));
                                    end else begin
                                        state_d = StDone;
                                    end
                                end
                            end
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= StIdle;
            ap_d1_q     <= 1'b0;
            ap_d2_q     <= 1'b0;
            setup_cnt_q <= '0;
            kxk_q       <= '0;
            kxk_ovf_q   <= 1'b0;
            cig_num_q   <= '0;
            cog_num_q   <= '0;
            kstep_q     <= '0;
            pix_num_q   <= '0;
            cig_cnt_q   <= '0;
            k_cnt_q     <= '0;
            pix_cnt_q   <= '0;
            cog_cnt_q   <= '0;
            addr_q      <= '0;
            kbase_q     <= '0;
            rd_addr_q   <= '0;
            rd_dv_q     <= 1'b0;
            rd_first_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ap_d1_q     <= I_ap_start;
            ap_d2_q     <= ap_d1_q;
            setup_cnt_q <= setup_cnt_d;
            kxk_q       <= kxk_d;
            kxk_ovf_q   <= kxk_ovf_d;
            cig_num_q   <= cig_num_d;
            cog_num_q   <= cog_num_d;
            kstep_q     <= kstep_d;
            pix_num_q   <= pix_num_d;
            cig_cnt_q   <= cig_cnt_d;
            k_cnt_q     <= k_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            cog_cnt_q   <= cog_cnt_d;
            addr_q      <= addr_d;
            kbase_q     <= kbase_d;
            rd_addr_q   <= rd_addr_d;
            rd_dv_q     <= rd_dv_d;
            rd_first_q  <= rd_first_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            // Shifts every cycle so stalls appear downstream as dv=0 bubbles.
            dly_q[0]    <= {rd_dv_q, rd_first_q, rd_last_q};
            for (int i = 1; i < RD_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign O_rd_wdepth = rd_addr_q;
    assign O_rd_dv     = rd_dv_q;
    assign O_w_dv      = dly_q[RD_LAT-1][2];
    assign O_w_first   = dly_q[RD_LAT-1][1];
    assign O_w_last    = dly_q[RD_LAT-1][0];
    assign O_busy      = busy_q;
    assign O_done      = done_q;
    assign O_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_weight_rd_sequencer.sv
// Directed self-checking bench for weight_rd_sequencer.
`timescale 1ns/1ps
module tb_weight_rd_sequencer;

    localparam int RD_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] kx, ky;
    logic [12:0] ci, co;
    logic [15:0] pix;
    logic        ap_start, load_done, stall;
    logic [8:0]  rd_wdepth;
    logic        rd_dv, w_dv, w_first, w_last, busy, done, cfg_err;

    int tests = 0;
    int fails = 0;

    logic [8:0] rd_addr [$];
    int         rd_cyc [$];
    bit         dv_hist [$];
    bit         wdv_hist [$];
    bit         wf [$];
    bit         wl [$];
    int         done_cyc, done_cnt;
    bit         timed_out;

    weight_rd_sequencer #(
        .LITEWIDTH(32), .COWIDTH(10), .CH_IN(16), .CH_OUT(32), .PIXWIDTH(16), .RD_LAT(RD_LAT)
    ) dut (
        .I_clk      (clk),
        .I_rst      (rst),
        .I_kx_num   (kx),
        .I_ky_num   (ky),
        .I_ciAlign  (ci),
        .I_coAlign  (co),
        .I_pix_num  (pix),
        .I_ap_start (ap_start),
        .I_load_done(load_done),
        .I_stall    (stall),
        .O_rd_wdepth(rd_wdepth),
        .O_rd_dv    (rd_dv),
        .O_w_dv     (w_dv),
        .O_w_first  (w_first),
        .O_w_last   (w_last),
        .O_busy     (busy),
        .O_done     (done),
        .O_cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic set_cfg(input int kx_v, input int ky_v, input int ci_v, input int co_v,
                           input int pix_v);
        kx  = 32'(kx_v);
        ky  = 32'(ky_v);
        ci  = 13'(ci_v);
        co  = 13'(co_v);
        pix = 16'(pix_v);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ap_start = 1'b1;
        repeat (2) @(negedge clk);
        ap_start = 1'b0;
    endtask

    // Samples at negedge until done has drained through the delay line or budget expires.
    task automatic collect(input int budget, input int stall_at, input int stall_len);
        int rem = 0;
        bit stall_used = 1'b0;
        int cyc = 0;
        rd_addr.delete(); rd_cyc.delete(); dv_hist.delete(); wdv_hist.delete();
        wf.delete(); wl.delete();
        done_cyc  = -1;
        done_cnt  = 0;
        timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            dv_hist.push_back(rd_dv);
            wdv_hist.push_back(w_dv);
            if (rd_dv) begin
                rd_addr.push_back(rd_wdepth);
                rd_cyc.push_back(cyc);
            end
            if (w_dv) begin
                wf.push_back(w_first);
                wl.push_back(w_last);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (rem > 0) begin
                rem--;
                if (rem == 0) stall = 1'b0;
            end else if (!stall_used && stall_len > 0 && rd_addr.size() == stall_at) begin
                stall      = 1'b1;
                rem        = stall_len;
                stall_used = 1'b1;
            end
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc + RD_LAT + 2) break;
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (rd_dv !== 1'b0) begin fails++; $display("FAIL reset_rd_dv: got %b want 0", rd_dv); end
        tests++; if (rd_wdepth !== 9'd0) begin fails++; $display("FAIL reset_wdepth: got %0d want 0", rd_wdepth); end
        tests++; if ({w_dv, w_first, w_last} !== 3'b000) begin fails++; $display("FAIL reset_w: got %b want 000", {w_dv, w_first, w_last}); end
        tests++; if ({busy, done, cfg_err} !== 3'b000) begin fails++; $display("FAIL reset_status: got %b want 000", {busy, done, cfg_err}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if ({rd_dv, busy} !== 2'b00) begin fails++; $display("FAIL reset_idle: got %b want 00", {rd_dv, busy}); end
    endtask

    task automatic test_basic();
        int bad = 0;
        int last_rd;
        set_cfg(3, 3, 32, 64, 1);
        pulse_start();
        collect(200, -1, 0);
        tests++; if (timed_out) begin fails++; $display("FAIL basic_timeout: got timeout want done"); end
        tests++; if (rd_addr.size() != 36) begin fails++; $display("FAIL basic_count: got %0d want 36", rd_addr.size()); end
        for (int i = 0; i < rd_addr.size(); i++) begin
            if (int'(rd_addr[i]) != 2 * (i % 18) + i / 18) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL basic_addr: got %0d wrong addresses want 0", bad); end
        bad = 0;
        for (int i = 0; i < wf.size(); i++) begin
            if (wf[i] != (i % 18 == 0) || wl[i] != (i % 18 == 17)) bad++;
        end
        tests++; if (bad != 0 || wf.size() != 36) begin fails++; $display("FAIL basic_flags: got %0d bad of %0d want 0 of 36", bad, wf.size()); end
        bad = 0;
        for (int t = RD_LAT; t < dv_hist.size(); t++) begin
            if (wdv_hist[t] != dv_hist[t-RD_LAT]) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL basic_delay: got %0d misaligned cycles want 0", bad); end
        last_rd = (rd_cyc.size() > 0) ? rd_cyc[rd_cyc.size()-1] : -100;
        tests++; if (done_cyc != last_rd + 1 || done_cnt != 1) begin fails++; $display("FAIL basic_done: got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, last_rd + 1); end
        tests++; if ({busy, cfg_err} !== 2'b00) begin fails++; $display("FAIL basic_idle: got %b want 00", {busy, cfg_err}); end
    endtask

    task automatic test_kernel_1x1();
        int bad = 0;
        int last_rd;
        set_cfg(1, 1, 16, 32, 3);
        pulse_start();
        collect(100, -1, 0);
        tests++; if (rd_addr.size() != 3 || timed_out) begin fails++; $display("FAIL k1_count: got %0d timeout %b want 3 0", rd_addr.size(), timed_out); end
        for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] != 9'd0) bad++;
        for (int i = 0; i < wf.size(); i++) if (!wf[i] || !wl[i]) bad++;
        tests++; if (bad != 0 || wf.size() != 3) begin fails++; $display("FAIL k1_addr_flags: got %0d bad of %0d want 0 of 3", bad, wf.size()); end
        last_rd = (rd_cyc.size() > 0) ? rd_cyc[rd_cyc.size()-1] : -100;
        tests++; if (done_cyc != last_rd + 1) begin fails++; $display("FAIL k1_done: got %0d want %0d", done_cyc, last_rd + 1); end
    endtask

    task automatic test_stall();
        int bad = 0;
        set_cfg(3, 3, 32, 64, 1);
        pulse_start();
        collect(200, 10, 5);
        tests++; if (rd_addr.size() != 36) begin fails++; $display("FAIL stall_count: got %0d want 36", rd_addr.size()); end
        for (int i = 0; i < rd_addr.size(); i++) begin
            if (int'(rd_addr[i]) != 2 * (i % 18) + i / 18) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL stall_addr: got %0d wrong addresses want 0", bad); end
        if (rd_cyc.size() > 10) begin
            tests++; if (rd_cyc[10] - rd_cyc[9] != 6 || rd_addr[10] != 9'd20) begin fails++; $display("FAIL stall_gap: got gap %0d addr %0d want 6 20", rd_cyc[10] - rd_cyc[9], rd_addr[10]); end
        end else begin
            tests++; fails++; $display("FAIL stall_gap: got %0d reads want more than 10", rd_cyc.size());
        end
        bad = 0;
        for (int t = RD_LAT; t < dv_hist.size(); t++) begin
            if (wdv_hist[t] != dv_hist[t-RD_LAT]) bad++;
        end
        tests++; if (bad != 0 || wf.size() != 36) begin fails++; $display("FAIL stall_delay: got %0d misaligned %0d wreads want 0 36", bad, wf.size()); end
    endtask

    task automatic test_load_wait();
        int dv_seen = 0;
        int idle_seen = 0;
        set_cfg(3, 3, 32, 64, 1);
        load_done = 1'b0;
        pulse_start();
        repeat (20) begin
            @(negedge clk);
            if (rd_dv) dv_seen++;
            if (!busy) idle_seen++;
        end
        tests++; if (dv_seen != 0 || idle_seen != 0) begin fails++; $display("FAIL load_hold: got %0d reads %0d idle want 0 0", dv_seen, idle_seen); end
        load_done = 1'b1;
        @(negedge clk);
        tests++; if (rd_dv !== 1'b0) begin fails++; $display("FAIL load_early: got dv %b want 0", rd_dv); end
        @(negedge clk);
        tests++; if (rd_dv !== 1'b1 || rd_wdepth !== 9'd0) begin fails++; $display("FAIL load_first: got dv %b addr %0d want 1 0", rd_dv, rd_wdepth); end
        collect(200, -1, 0);
        tests++; if (rd_addr.size() != 35 || (rd_addr.size() > 0 && rd_addr[0] != 9'd2)) begin fails++; $display("FAIL load_rest: got %0d reads want 35 from addr 2", rd_addr.size()); end
    endtask

    task automatic test_cfg_err();
        set_cfg(5, 5, 256, 64, 1);
        pulse_start();
        collect(60, -1, 0);
        tests++; if (rd_addr.size() != 0 || done_cnt != 1 || timed_out) begin fails++; $display("FAIL err_run: got %0d reads %0d done want 0 1", rd_addr.size(), done_cnt); end
        tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL err_flag: got %b want 1", cfg_err); end
        set_cfg(1, 1, 16, 32, 3);
        pulse_start();
        collect(100, -1, 0);
        tests++; if (cfg_err !== 1'b0 || rd_addr.size() != 3) begin fails++; $display("FAIL err_clear: got err %b reads %0d want 0 3", cfg_err, rd_addr.size()); end
        set_cfg(3, 3, 32, 64, 0);
        pulse_start();
        collect(60, -1, 0);
        tests++; if (rd_addr.size() != 0 || done_cnt != 1 || cfg_err !== 1'b0) begin fails++; $display("FAIL zero_pix: got reads %0d done %0d err %b want 0 1 0", rd_addr.size(), done_cnt, cfg_err); end
    endtask

    task automatic test_restart_reset();
        int n = 0;
        int guard = 0;
        set_cfg(3, 3, 32, 64, 1);
        pulse_start();
        while (n < 10 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (rd_dv) n++;
        end
        tests++; if (n != 10) begin fails++; $display("FAIL restart_reach: got %0d reads want 10", n); end
        ap_start = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (rd_dv !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL restart_drop: got dv %b busy %b want 0 1", rd_dv, busy); end
        ap_start = 1'b0;
        guard = 0;
        while (!rd_dv && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        tests++; if (rd_dv !== 1'b1 || rd_wdepth !== 9'd0) begin fails++; $display("FAIL restart_addr0: got dv %b addr %0d want 1 0", rd_dv, rd_wdepth); end
        @(negedge clk);
        tests++; if (rd_dv !== 1'b1 || rd_wdepth !== 9'd2) begin fails++; $display("FAIL restart_addr1: got dv %b addr %0d want 1 2", rd_dv, rd_wdepth); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if ({rd_dv, rd_wdepth, w_dv, w_first, w_last, busy, done, cfg_err} !== 16'd0) begin fails++; $display("FAIL midreset_outputs: got %h want 0", {rd_dv, rd_wdepth, w_dv, w_first, w_last, busy, done, cfg_err}); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({rd_dv, w_dv, busy} !== 3'b000) begin fails++; $display("FAIL midreset_idle: got %b want 000", {rd_dv, w_dv, busy}); end
    endtask

    initial begin
        rst       = 1'b1;
        ap_start  = 1'b0;
        load_done = 1'b1;
        stall     = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_kernel_1x1();
        test_stall();
        test_load_wait();
        test_cfg_err();
        test_restart_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
